// File: rtl/gpi_debounce.sv
// Board-input conditioner: per-bit 2-flop synchroniser, counter debounce and
// registered edge pulses, plus one sticky maskable change interrupt.

module gpi_debounce_bit #(
  parameter int   DebounceCycles = 50000,
  parameter int   CW             = $clog2(DebounceCycles + 1),
  parameter logic RV             = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);
  localparam logic [CW-1:0] CNT_MAX = CW'(DebounceCycles - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= RV;
      s2     <= RV;
      stable <= RV;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      // Any sample agreeing with the accepted level throws away a partial count.
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= s2;
        cnt    <= '0;
        rise   <= s2;
        fall   <= ~s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module gpi_debounce #(
  parameter int               Width          = 20,
  parameter int               DebounceCycles = 50000,
  parameter logic [Width-1:0] ResetValue     = '0
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_ni,
  input  logic [Width-1:0] raw_i,
  input  logic [Width-1:0] irq_mask_i,
  input  logic             irq_clr_i,
  output logic [Width-1:0] stable_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic             irq_o
);
  for (genvar i = 0; i < Width; i++) begin : g_lane
    gpi_debounce_bit #(
      .DebounceCycles(DebounceCycles),
      .RV            (ResetValue[i])
    ) u_bit (
      .clk   (clk_sys_i),
      .rst_n (rst_sys_ni),
      .raw   (raw_i[i]),
      .stable(stable_o[i]),
      .rise  (rise_o[i]),
      .fall  (fall_o[i])
    );
  end

  // A new event in the same cycle as a clear keeps irq set so nothing is lost.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) irq_o <= 1'b0;
    else             irq_o <= (irq_o & ~irq_clr_i) | (|((rise_o | fall_o) & irq_mask_i));
  end
endmodule

// File: tb/tb_gpi_debounce.sv
// Randomised + directed bench for gpi_debounce with a sliding-window reference
// model feeding a pulse scoreboard; a second instance covers a non-zero reset value.

module tb_gpi_debounce;
  localparam int W = 4;
  localparam int D = 8;
  localparam logic [W-1:0] RV = '0;

  typedef struct packed {
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] raw = '0, mask = '0;
  logic         clr = 1'b0;
  logic [W-1:0] stable_o, rise_o, fall_o;
  logic         irq_o;
  logic [W-1:0] f_raw = '0, f_mask = '0;
  logic         f_clr = 1'b0;
  logic [W-1:0] f_stable, f_rise, f_fall;
  logic         f_irq;

  int n_checks = 0, n_pass = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  gpi_debounce #(.Width(W), .DebounceCycles(D), .ResetValue(RV)) dut (
    .clk_sys_i(clk), .rst_sys_ni(rst_n), .raw_i(raw), .irq_mask_i(mask),
    .irq_clr_i(clr), .stable_o(stable_o), .rise_o(rise_o), .fall_o(fall_o), .irq_o(irq_o));

  gpi_debounce #(.Width(W), .DebounceCycles(D), .ResetValue(4'hF)) dut_f (
    .clk_sys_i(clk), .rst_sys_ni(rst_n), .raw_i(f_raw), .irq_mask_i(f_mask),
    .irq_clr_i(f_clr), .stable_o(f_stable), .rise_o(f_rise), .fall_o(f_fall), .irq_o(f_irq));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: a bit's accepted level flips once the last D synchronised samples
  // (input delayed two clocks, preloaded with the reset value) all disagree with it.
  logic [W-1:0] mst = RV, prise = '0, pfall = '0;
  logic         mirq = 1'b0;
  logic [W-1:0] ext[$];
  initial begin
    logic [W-1:0] nr, nf;
    logic         cur, same;
    int           sz, lo;
    ext = {RV, RV};
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mst = RV; mirq = 1'b0; prise = '0; pfall = '0;
        ext = {RV, RV};
        q.delete();
      end else begin
        mirq = (mirq & ~clr) | (|((prise | pfall) & mask));
        nr = '0; nf = '0;
        sz = ext.size();
        lo = sz - 1 - D;
        if (lo >= 0) begin
          for (int b = 0; b < W; b++) begin
            cur  = ext[sz-2][b];
            same = 1'b1;
            for (int k = lo; k <= sz - 2; k++) if (ext[k][b] != cur) same = 1'b0;
            if (same && cur != mst[b]) begin
              mst[b] = cur;
              if (cur) nr[b] = 1'b1; else nf[b] = 1'b1;
            end
          end
        end
        if ((nr | nf) != '0) q.push_back('{rise: nr, fall: nf});
        prise = nr; pfall = nf;
        ext.push_back(raw);
        if (ext.size() > D + 2) void'(ext.pop_front());
      end
    end
  end

  // Monitor: level and irq every cycle; pulses drained from the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      check("stable", 32'(stable_o), 32'(mst));
      check("irq", 32'(irq_o), 32'(mirq));
      if ((rise_o | fall_o) !== '0) begin
        if (q.size() == 0) begin
          check("spurious_pulse", 32'({rise_o, fall_o}), 32'(0));
        end else begin
          e = q.pop_front();
          check("pulse_rise", 32'(rise_o), 32'(e.rise));
          check("pulse_fall", 32'(fall_o), 32'(e.fall));
        end
      end else if (q.size() != 0) begin
        e = q.pop_front();
        check("missed_pulse", 32'({rise_o, fall_o}), 32'({e.rise, e.fall}));
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    mask = 4'b0001;
    cyc(2);
    check("reset_stable", 32'(stable_o), 32'(0));
    check("reset_pulses", 32'({rise_o, fall_o}), 32'(0));
    check("reset_irq", 32'(irq_o), 32'(0));
    check("reset_f_stable", 32'(f_stable), 32'hF);
    @(posedge clk); #3 rst_n = 1'b1;

    // ResetValue=F with raw low: one fall pulse on all bits on the 10th edge.
    cyc(10);
    check("rv_f_before", 32'({f_stable, f_fall}), 32'h0F0);
    cyc(1);
    check("rv_f_fall", 32'({f_stable, f_fall}), 32'h00F);
    cyc(1);
    check("rv_f_after", 32'(f_fall), 32'(0));

    // Latency: bits 0 and 3 change together, only bit 0 unmasked.
    raw = 4'b1001;
    cyc(9);
    check("lat_before", 32'(stable_o), 32'(0));
    cyc(1);
    check("lat_stable", 32'(stable_o), 32'h9);
    check("lat_rise", 32'(rise_o), 32'h9);
    check("lat_irq_not_yet", 32'(irq_o), 32'(0));
    cyc(1);
    check("lat_rise_one_cycle", 32'(rise_o), 32'(0));
    check("lat_irq_set", 32'(irq_o), 32'(1));
    clr = 1'b1; cyc(1); clr = 1'b0;
    check("irq_cleared", 32'(irq_o), 32'(0));

    raw[3] = 1'b0;
    cyc(12);
    check("masked_bit3_no_irq", 32'(irq_o), 32'(0));

    // Clear coinciding with a new unmasked event: set wins.
    raw[0] = 1'b0;
    for (int i = 0; i < 20 && fall_o[0] !== 1'b1; i++) cyc(1);
    check("fall0_seen", 32'(fall_o[0]), 32'(1));
    clr = 1'b1; cyc(1); clr = 1'b0;
    check("set_wins_clear", 32'(irq_o), 32'(1));

    // Short glitch on bit 1 is rejected.
    raw[1] = 1'b1; cyc(5); raw[1] = 1'b0;
    cyc(15);
    check("glitch_rejected", 32'(stable_o[1]), 32'(0));

    // Bounce bit 2 every 3 cycles, then settle high.
    for (int i = 0; i < 10; i++) begin raw[2] = ~raw[2]; cyc(3); end
    raw[2] = 1'b1;
    cyc(9);
    check("bounce_before", 32'(stable_o[2]), 32'(0));
    cyc(1);
    check("bounce_rise", 32'({stable_o[2], rise_o[2]}), 32'h3);

    // Randomised phase with varying toggle density, mask and clear strobes.
    for (int ph = 0; ph < 8; ph++) begin
      int p;
      p = (ph % 4 == 0) ? 2 : (ph % 4 == 1) ? 4 : (ph % 4 == 2) ? 10 : 24;
      mask = W'($urandom);
      for (int c = 0; c < 100; c++) begin
        for (int b = 0; b < W; b++) if ($urandom % p == 0) raw[b] = ~raw[b];
        clr = ($urandom % 5 == 0);
        cyc(1);
      end
    end
    clr = 1'b0;

    // Reset mid-count while stable is high.
    raw = 4'hF; cyc(14);
    check("pre_reset_stable", 32'(stable_o), 32'hF);
    raw = 4'h0; cyc(7);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("midcount_reset_stable", 32'(stable_o), 32'(0));
    check("midcount_reset_pulses", 32'({rise_o, fall_o}), 32'(0));
    check("midcount_reset_irq", 32'(irq_o), 32'(0));
    cyc(3);
    @(posedge clk); #3 rst_n = 1'b1;
    cyc(20);
    check("post_reset_stable", 32'(stable_o), 32'(0));

    check("scoreboard_drained", 32'(q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
